// File: rtl/perlin_ctrl_pkg.sv
// Shared types and constants for the Perlin animation controller.
// State encoding, time width and the darkest fade level.
package perlin_ctrl_pkg;

  localparam int T_WIDTH = 20;
  localparam logic [1:0] FADE_MAX = 2'd3;

  typedef enum logic [1:0] {
    RUN,
    FADE_OUT,
    SWAP,
    FADE_IN
  } state_e;

endpackage

// File: rtl/perlin_time_acc.sv
// Noise time accumulator: steps t by +/-(1 << speed) on each
// unpaused frame tick, wrapping modulo 2^T_WIDTH.
module perlin_time_acc
  import perlin_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic [1:0]         speed,
  input  logic               reverse,
  output logic [T_WIDTH-1:0] t
);

  logic [T_WIDTH-1:0] t_q;
  logic [T_WIDTH-1:0] t_d;
  logic [T_WIDTH-1:0] step;

  // Next time value, only moves on an unpaused frame tick
  always_comb begin
    step = T_WIDTH'(1) << speed;
    t_d  = t_q;
    if (frame_tick && !pause) begin
      t_d = reverse ? (t_q - step) : (t_q + step);
    end
  end

  // Time register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  assign t = t_q;

endmodule

// File: rtl/perlin_anim_ctrl.sv
// Frame-level animation controller: time sequencing plus a
// fade-out/swap/fade-in pattern FSM. Optional PERLIN_AUTOCYCLE_EN.
module perlin_anim_ctrl
  import perlin_ctrl_pkg::*;
#(
  parameter int FADE_FRAMES = 4,
  parameter int AUTO_PERIOD = 600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic [1:0]         speed,
  input  logic               reverse,
  input  logic               switch_req,
  output logic [T_WIDTH-1:0] t,
  output logic               pattern_sel,
  output logic [1:0]         fade,
  output logic               busy
);

  if (FADE_FRAMES < 1 || FADE_FRAMES > 255 ||
      AUTO_PERIOD < 2 || AUTO_PERIOD > 65535) begin : g_bad_params
    $error("perlin_anim_ctrl: parameter out of range");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] fade_q, fade_d;
  logic       pat_q, pat_d;
  logic       busy_q, busy_d;
  logic       req;
  logic       step_hit;

  perlin_time_acc u_time (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .pause      (pause),
    .speed      (speed),
    .reverse    (reverse),
    .t          (t)
  );

`ifdef PERLIN_AUTOCYCLE_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic        auto_req;

  // Auto-switch frame counter; holds while busy, clears in SWAP
  always_comb begin
    fcnt_d   = fcnt_q;
    auto_req = 1'b0;
    if (state_q == RUN && frame_tick && !pause) begin
      if (fcnt_q == 16'(AUTO_PERIOD - 1)) begin
        fcnt_d   = '0;
        auto_req = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 16'd1;
      end
    end else if (state_q == SWAP) begin
      fcnt_d = '0;
    end
  end

  // Auto-switch counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign req = switch_req | auto_req;
`else
  assign req = switch_req;
`endif

  assign step_hit = frame_tick && (cnt_q == 8'(FADE_FRAMES - 1));

  // Transition FSM next state; a tick only counts inside a fade state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fade_d  = fade_q;
    pat_d   = pat_q;
    busy_d  = busy_q;
    unique case (state_q)
      RUN: begin
        if (req) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FADE_OUT: begin
        if (step_hit) begin
          cnt_d = '0;
          if (fade_q == FADE_MAX) begin
            state_d = SWAP;
          end else begin
            fade_d = fade_q + 2'd1;
          end
        end else if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SWAP: begin
        pat_d   = ~pat_q;
        state_d = FADE_IN;
        cnt_d   = '0;
      end
      FADE_IN: begin
        if (step_hit) begin
          cnt_d  = '0;
          fade_d = fade_q - 2'd1;
          if (fade_q == 2'd1) begin
            state_d = RUN;
            busy_d  = 1'b0;
          end
        end else if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fade_q  <= '0;
      pat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fade_q  <= fade_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
    end
  end

  assign pattern_sel = pat_q;
  assign fade        = fade_q;
  assign busy        = busy_q;

endmodule
